// File: rtl/rtc_calendar_ctrl.sv
// Real-time clock/calendar: prescaled one-second cascade with Gregorian leap rule,
// validated time/date load, and an eight-digit active-low 7-segment display.
module rtc_calendar_ctrl #(
    parameter int unsigned TICK_DIV  = 50000000,
    parameter int unsigned RST_YEAR  = 2024,
    parameter int unsigned RST_MONTH = 1,
    parameter int unsigned RST_DAY   = 1,
    parameter int unsigned YEAR_MAX  = 9999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        mode,
    input  logic        h12,
    input  logic        set_valid,
    input  logic        set_target,
    input  logic [22:0] set_data,
    output logic        set_ack,
    output logic        set_err,
    output logic        sec_tick,
    output logic        pm,
    output logic [55:0] seg_o
);
    localparam int unsigned   PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [13:0]   YMAX     = 14'(YEAR_MAX);

    function automatic logic is_leap(input logic [13:0] y);
        return (((y % 14'd4) == 14'd0) && ((y % 14'd100) != 14'd0)) || ((y % 14'd400) == 14'd0);
    endfunction

    function automatic logic [4:0] dim(input logic [3:0] m, input logic [13:0] y);
        case (m)
            4'd2:                     return is_leap(y) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:  return 5'd30;
            default:                  return 5'd31;
        endcase
    endfunction

    // Digit value 4'hF renders blank.
    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    logic [PW-1:0] pre_q, pre_d;
    logic [5:0]    sec_q, sec_d, min_q, min_d;
    logic [4:0]    hour_q, hour_d, day_q, day_d;
    logic [3:0]    mon_q, mon_d;
    logic [13:0]   year_q, year_d;
    logic [55:0]   seg_q, seg_d;
    logic          pm_q, ack_q, err_q, tick_q;

    logic [4:0]  ld_hour, ld_day;
    logic [5:0]  ld_min, ld_sec;
    logic [3:0]  ld_mon;
    logic [13:0] ld_year;
    logic        tick, time_ok, date_ok, load_ok;

    assign ld_hour = set_data[16:12];
    assign ld_min  = set_data[11:6];
    assign ld_sec  = set_data[5:0];
    assign ld_year = set_data[22:9];
    assign ld_mon  = set_data[8:5];
    assign ld_day  = set_data[4:0];

    assign tick    = run && (pre_q == PRE_LAST);
    assign time_ok = (ld_hour <= 5'd23) && (ld_min <= 6'd59) && (ld_sec <= 6'd59);
    assign date_ok = (ld_mon >= 4'd1) && (ld_mon <= 4'd12) && (ld_year <= YMAX) &&
                     (ld_day >= 5'd1) && (ld_day <= dim(ld_mon, ld_year));
    assign load_ok = set_valid && (set_target ? date_ok : time_ok);

    // An accepted load takes priority and swallows a coincident tick.
    always_comb begin
        pre_d  = pre_q;
        sec_d  = sec_q;
        min_d  = min_q;
        hour_d = hour_q;
        day_d  = day_q;
        mon_d  = mon_q;
        year_d = year_q;
        if (run) pre_d = tick ? '0 : pre_q + 1'b1;
        if (load_ok) begin
            if (set_target) begin
                year_d = ld_year;
                mon_d  = ld_mon;
                day_d  = ld_day;
            end else begin
                hour_d = ld_hour;
                min_d  = ld_min;
                sec_d  = ld_sec;
                pre_d  = '0;
            end
        end else if (tick) begin
            if (sec_q != 6'd59) sec_d = sec_q + 6'd1;
            else begin
                sec_d = '0;
                if (min_q != 6'd59) min_d = min_q + 6'd1;
                else begin
                    min_d = '0;
                    if (hour_q != 5'd23) hour_d = hour_q + 5'd1;
                    else begin
                        hour_d = '0;
                        if (day_q != dim(mon_q, year_q)) day_d = day_q + 5'd1;
                        else begin
                            day_d = 5'd1;
                            if (mon_q != 4'd12) mon_d = mon_q + 4'd1;
                            else begin
                                mon_d  = 4'd1;
                                year_d = (year_q == YMAX) ? 14'd0 : year_q + 14'd1;
                            end
                        end
                    end
                end
            end
        end
    end

    logic [4:0]      disp_hour;
    logic [7:0][3:0] dig;

    always_comb begin
        disp_hour = hour_q;
        if (h12) begin
            if (hour_q == 5'd0)       disp_hour = 5'd12;
            else if (hour_q > 5'd12)  disp_hour = hour_q - 5'd12;
        end
        dig = '1;
        if (mode) begin
            dig[7] = 4'(day_q / 5'd10);
            dig[6] = 4'(day_q % 5'd10);
            dig[5] = 4'(mon_q / 4'd10);
            dig[4] = 4'(mon_q % 4'd10);
            dig[3] = 4'(year_q / 14'd1000);
            dig[2] = 4'((year_q / 14'd100) % 14'd10);
            dig[1] = 4'((year_q / 14'd10) % 14'd10);
            dig[0] = 4'(year_q % 14'd10);
        end else begin
            if (!(h12 && disp_hour < 5'd10)) dig[7] = 4'(disp_hour / 5'd10);
            dig[6] = 4'(disp_hour % 5'd10);
            dig[5] = 4'(min_q / 6'd10);
            dig[4] = 4'(min_q % 6'd10);
            dig[3] = 4'(sec_q / 6'd10);
            dig[2] = 4'(sec_q % 6'd10);
        end
        seg_d = '0;
        for (int d = 0; d < 8; d++) seg_d[7*d +: 7] = seg7(dig[d]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q  <= '0;
            sec_q  <= '0;
            min_q  <= '0;
            hour_q <= '0;
            day_q  <= 5'(RST_DAY);
            mon_q  <= 4'(RST_MONTH);
            year_q <= 14'(RST_YEAR);
            seg_q  <= {8{7'h7F}};
            pm_q   <= 1'b0;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            sec_q  <= sec_d;
            min_q  <= min_d;
            hour_q <= hour_d;
            day_q  <= day_d;
            mon_q  <= mon_d;
            year_q <= year_d;
            seg_q  <= seg_d;
            pm_q   <= (hour_q >= 5'd12);
            ack_q  <= load_ok;
            err_q  <= set_valid && !load_ok;
            tick_q <= tick && !load_ok;
        end
    end

    assign set_ack  = ack_q;
    assign set_err  = err_q;
    assign sec_tick = tick_q;
    assign pm       = pm_q;
    assign seg_o    = seg_q;
endmodule

// File: doc/rtc_calendar_ctrl.md
Name: rtc_calendar_ctrl

Overview:
Parametrised real-time clock/calendar that produces eight multiplexed active-low 7-segment digit codes. It has an internal one-second prescaler and a run/pause control. It supports a 12/24-hour display mode and applies the full Gregorian leap-year rule. A validated load handshake sets time or date. It sits between the board clock and the eight-digit display bank, replacing the fixed-rate counter.

Parameters:
TICK_DIV, 50000000, clk cycles per one-second tick (>=2)
RST_YEAR, 2024, year loaded at reset (0..YEAR_MAX)
RST_MONTH, 1, month loaded at reset (1..12)
RST_DAY, 1, day loaded at reset (valid for RST_MONTH/RST_YEAR)
YEAR_MAX, 9999, last year before wrap to 0 (<=9999)

Ports:
clk  in  1  system clock, single clock domain
rst_n  in  1  reset; asynchronous, active-low
run  in  1  1 = prescaler counts; 0 = time frozen
mode  in  1  0 = time display, 1 = date display
h12  in  1  1 = 12-hour display, 0 = 24-hour
set_valid  in  1  load request, level, sampled each clk
set_target  in  1  0 = time load, 1 = date load
set_data  in  23  time: [16:12] hour, [11:6] min, [5:0] sec; date: [22:9] year, [8:5] month, [4:0] day (binary)
set_ack  out  1  one-cycle pulse: load accepted
set_err  out  1  one-cycle pulse: load rejected
sec_tick  out  1  one-cycle pulse per counted second
pm  out  1  1 when hour >= 12 (valid in both h12 modes)
seg_o  out  56  digit d at [7d+6:7d], d=7 leftmost; bit0 = segment a; active-low

Behaviour:
- Reset (async, rst_n=0): sec=min=hour=0, day/month/year = RST_*, prescaler=0. Outputs: seg_o all 7'h7F (blank), pm/set_ack/set_err/sec_tick = 0.
- Prescaler: width clog2(TICK_DIV). Increments when run=1. At TICK_DIV-1 it wraps to 0 and asserts an internal tick. With run=0 it holds its value.
- On tick: sec_tick=1 on the next cycle, and the time/date cascade advances by one second.
  - sec 59 -> 0, carry to min.
  - min 59 -> 0, carry to hour.
  - hour 23 -> 0, carry to day.
  - day == dim(month, year) -> 1, carry to month.
  - month 12 -> 1, carry to year.
  - year == YEAR_MAX -> 0.
- dim = 31 for months {1,3,5,7,8,10,12} and 30 for {4,6,9,11}. February is 29 when leap, else 28. Leap = (y%4==0 && y%100!=0) || y%400==0.
- Load handshake: checked every cycle set_valid=1; each such cycle is one request.
  - Time load is valid iff hour<=23, min<=59, sec<=59.
  - Date load is valid iff 1<=month<=12, year<=YEAR_MAX, 1<=day<=dim(month, year).
  - Valid load: fields are written at the clk edge, and set_ack pulses the following cycle. A time load also clears the prescaler.
  - Invalid load: counters are unchanged, and set_err pulses the following cycle.
  - Load and tick in the same cycle: the load wins and that tick is discarded entirely, with no sec_tick and no carry.
- Display: seg_o is a registered output, 1-cycle latency from counter or mode/h12 change.
  - Time mode: d7..d2 = H1 H0 M1 M0 S1 S0; d1, d0 blank.
  - 12-hour conversion: hour 0 -> 12, 13..23 -> 1..11. H1 is blank when the displayed hour < 10.
  - Date mode: d7..d0 = D1 D0 Mo1 Mo0 Y3 Y2 Y1 Y0, year zero-padded.
- Digit codes, active-low {g..a}: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex); blank = 7F.
- pm is registered alongside seg_o.
- Reset asserted mid-operation returns immediately to the reset state. A load in flight is lost, with no ack or err.

Test Plan:
- TICK_DIV=4, after reset, run=1: after 4 cycles sec_tick pulses and sec=1. With mode=0, d7..d2 = 40 40 40 40 40 79, and d1 and d0 = 7F.
- Time load 23:59:59, date 31/12/YEAR_MAX, then one tick: result is 00:00:00 01/01/0000 and pm goes 1 -> 0.
- Leap year: 28/02/2100 + 1 day -> 01/03. 28/02/2000 + 1 day -> 29/02. 28/02/2024 + 1 day -> 29/02.
- Date load 29/02/2023 -> set_err pulse with date unchanged. Date load 29/02/2024 -> set_ack pulse and date updated.
- Time load 12:00:00 -> with h12=1, pm=1. Time load 13:05:00 -> with h12=1, display d7..d2 = 7F 79 40 12 40 40. Time load 00:00:00 -> with h12=1, shows 12 and pm=0.
- Load on the exact tick cycle -> the loaded value is held, with no sec_tick that cycle. With run=0 for 20 cycles -> no sec_tick pulses.
